cga_vram_arbiter: RTL and testbench
===================================

Name: cga_vram_arbiter

Overview:
- Sits directly downstream of the CGA sequencer and consumes its timing strobes.
- Owns the single-ported 16 KB video SRAM and time-multiplexes it between two masters:
  - display fetches, which latch the character and attribute bytes for the pixel pipeline;
  - ISA host reads and writes, which run as 3-cycle operations inside the sequencer's ISA windows.
- Provides host wait and acknowledge handshaking.

Parameters:
- ADDR_W, 14, VRAM byte address width.
- START_LIMIT, 11, last clk_seq[3:0] value at which an ISA operation may start, so the operation ends at least 2 cycles before vram_read.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_seq  in  5  sequencer phase count, 0..31.
- vram_read  in  1  display owns SRAM this cycle.
- vram_read_a0  in  1  SRAM address bit 0 for the display fetch.
- vram_read_char  in  1  sample character byte at the end of this cycle.
- vram_read_att  in  1  sample attribute byte at the end of this cycle.
- isa_op_enable  in  1  ISA access window.
- disp_addr  in  ADDR_W-1  display word address from CRTC/address logic.
- bus_rd_req  in  1  one-cycle pulse: host read request.
- bus_wr_req  in  1  one-cycle pulse: host write request.
- bus_addr  in  ADDR_W  host byte address, stable while bus_wait=1.
- bus_din  in  8  host write data, stable while bus_wait=1.
- bus_dout  out  8  host read data, valid from bus_ack onward.
- bus_ack  out  1  one-cycle completion pulse.
- bus_wait  out  1  high from the cycle after a request until bus_ack (drives IOCHRDY low).
- ram_a  out  ADDR_W  SRAM address.
- ram_d_in  in  8  SRAM read data.
- ram_d_out  out  8  SRAM write data.
- ram_d_oe  out  1  FPGA drives the SRAM data bus.
- ram_oe_l  out  1  SRAM output enable, active low.
- ram_we_l  out  1  SRAM write enable, active low.
- char_byte  out  8  latched character byte.
- attr_byte  out  8  latched attribute byte.

Behaviour:
- Reset (asynchronous, applies mid-operation too):
  - FSM goes to IDLE and the pending request is discarded.
  - char_byte=0, attr_byte=0, bus_dout=0, bus_ack=0, bus_wait=0.
  - ram_we_l=1, ram_oe_l=1, ram_d_oe=0, ram_a=0, ram_d_out=0.
- FSM states: IDLE, PEND, SETUP, STROBE, HOLD.
  - IDLE: on bus_wr_req or bus_rd_req, latch the op type (write wins if both), bus_addr and bus_din, then go to PEND. Set bus_wait=1 in the next cycle.
  - PEND: go to SETUP when isa_op_enable=1 and clk_seq[3:0] <= START_LIMIT. Valid start phases are therefore 5..11 and 21..27.
  - SETUP -> STROBE -> HOLD -> IDLE, unconditionally, one cycle each.
  - HOLD: bus_ack=1 for exactly that cycle; bus_wait drops in the same cycle.
  - Requests arriving in any state other than IDLE are ignored. The host is stalled by bus_wait.
- SRAM control (combinational decode of state and strobes):
  - vram_read=1: ram_a={disp_addr, vram_read_a0}, ram_oe_l=0, ram_we_l=1, ram_d_oe=0. The display always takes priority.
  - SETUP, STROBE, HOLD: ram_a=latched host address. For a write, ram_d_oe=1 in all three states and ram_we_l=0 only in STROBE. For a read, ram_oe_l=0 in STROBE and HOLD.
  - Otherwise: ram_a=0, ram_oe_l=1, ram_we_l=1, ram_d_oe=0.
- Data capture:
  - char_byte <= ram_d_in at the end of a cycle with vram_read_char=1.
  - attr_byte <= ram_d_in at the end of a cycle with vram_read_att=1.
  - Between strobes both bytes hold their value.
  - bus_dout <= ram_d_in at the end of a read STROBE; it holds until the next read completes.
- Latency:
  - Best case: 4 cycles from request to bus_ack (request in IDLE at phase 4, PEND at 5, SETUP at 6, ack at 8).
  - Worst case: request at phase 12 waits until phase 21; SETUP at 22, bus_ack at 24.
- Collision: vram_read=1 while the FSM is in SETUP/STROBE/HOLD is illegal by construction. The bench asserts it never occurs.

Test Plan:
- Reset asserted mid-STROBE of a write -> ram_we_l=1 and ram_d_oe=0 immediately; after release the FSM is in IDLE, bus_wait=0, and SRAM content is unaltered.
- SRAM model with addr 0x0100=0x41 and 0x0101=0x1F, disp_addr=0x080, hres_mode sequencer -> char_byte=0x41 after phase 2, attr_byte=0x1F after phase 3; the same pair is refetched at phases 18/19.
- bus_wr_req pulse at phase 4, addr 0x1234, data 0xA5 -> SETUP at 6, ram_we_l low only at 7, bus_ack at 8; SRAM[0x1234]=0xA5.
- bus_rd_req at phase 12, addr 0x1234 -> bus_wait held through phases 13..23, SETUP at 22, bus_ack at 24 with bus_dout=0xA5; no ISA activity during phases 13..21.
- bus_rd_req and bus_wr_req in the same cycle -> write performed, no read; a second request during bus_wait is ignored, giving exactly one bus_ack.
- Random requests over 10k cycles across both hres settings -> never any overlap of vram_read with ISA states; display bytes always match the SRAM model.

Source files
------------

// File: rtl/cga_vram_arbiter.sv
// Video SRAM arbiter: display fetches own the SRAM on sequencer strobes, host
// ISA reads/writes run as SETUP/STROBE/HOLD operations inside the ISA windows.
module cga_vram_arbiter #(
   parameter int ADDR_W      = 14,
   parameter int START_LIMIT = 11
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [4:0]        clk_seq,
   input  logic              vram_read,
   input  logic              vram_read_a0,
   input  logic              vram_read_char,
   input  logic              vram_read_att,
   input  logic              isa_op_enable,
   input  logic [ADDR_W-2:0] disp_addr,
   input  logic              bus_rd_req,
   input  logic              bus_wr_req,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [7:0]        bus_din,
   output logic [7:0]        bus_dout,
   output logic              bus_ack,
   output logic              bus_wait,
   output logic [ADDR_W-1:0] ram_a,
   input  logic [7:0]        ram_d_in,
   output logic [7:0]        ram_d_out,
   output logic              ram_d_oe,
   output logic              ram_oe_l,
   output logic              ram_we_l,
   output logic [7:0]        char_byte,
   output logic [7:0]        attr_byte
);

   typedef enum logic [2:0] {IDLE, PEND, SETUP, STROBE, HOLD} state_t;

   state_t            state_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        din_q;
   logic              bus_ack_q;
   logic              bus_wait_q;
   logic [7:0]        char_q;
   logic [7:0]        attr_q;
   logic [7:0]        dout_q;

   logic [ADDR_W-1:0] ram_a_d;
   logic [7:0]        ram_d_out_d;
   logic              ram_d_oe_d;
   logic              ram_oe_l_d;
   logic              ram_we_l_d;

   logic              start_ok;
   logic              isa_active;
   logic              unused_seq;

   // Only the phase within a half-line matters; the half bit is irrelevant here.
   assign unused_seq = clk_seq[4];
   assign start_ok   = isa_op_enable && (clk_seq[3:0] <= 4'(START_LIMIT));
   assign isa_active = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= 8'h00;
         bus_ack_q  <= 1'b0;
         bus_wait_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               bus_ack_q <= 1'b0;
               if (bus_wr_req || bus_rd_req) begin
                  wr_q       <= bus_wr_req;
                  addr_q     <= bus_addr;
                  din_q      <= bus_din;
                  bus_wait_q <= 1'b1;
                  state_q    <= PEND;
               end
            end
            PEND: begin
               if (start_ok) state_q <= SETUP;
            end
            SETUP: state_q <= STROBE;
            STROBE: begin
               bus_ack_q  <= 1'b1;
               bus_wait_q <= 1'b0;
               state_q    <= HOLD;
            end
            HOLD: begin
               bus_ack_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         char_q <= 8'h00;
         attr_q <= 8'h00;
         dout_q <= 8'h00;
      end else begin
         if (vram_read_char) char_q <= ram_d_in;
         if (vram_read_att)  attr_q <= ram_d_in;
         if ((state_q == STROBE) && !wr_q) dout_q <= ram_d_in;
      end
   end

   // Display fetch always wins; the sequencer keeps ISA operations clear of it.
   always_comb begin
      ram_a_d     = '0;
      ram_d_out_d = 8'h00;
      ram_d_oe_d  = 1'b0;
      ram_oe_l_d  = 1'b1;
      ram_we_l_d  = 1'b1;
      if (vram_read) begin
         ram_a_d    = {disp_addr, vram_read_a0};
         ram_oe_l_d = 1'b0;
      end else if (isa_active) begin
         ram_a_d = addr_q;
         if (wr_q) begin
            ram_d_oe_d  = 1'b1;
            ram_d_out_d = din_q;
            ram_we_l_d  = (state_q != STROBE);
         end else begin
            ram_oe_l_d = (state_q == SETUP);
         end
      end
   end

   assign ram_a     = ram_a_d;
   assign ram_d_out = ram_d_out_d;
   assign ram_d_oe  = ram_d_oe_d;
   assign ram_oe_l  = ram_oe_l_d;
   assign ram_we_l  = ram_we_l_d;
   assign bus_ack   = bus_ack_q;
   assign bus_wait  = bus_wait_q;
   assign bus_dout  = dout_q;
   assign char_byte = char_q;
   assign attr_byte = attr_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Bench for cga_vram_arbiter: behavioural sequencer + SRAM model, directed
// phase tables for the host corner cases, then randomized traffic against a scheduler model.
module tb_cga_vram_arbiter;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [4:0]    clk_seq;
   logic          vram_read, vram_read_a0, vram_read_char, vram_read_att, isa_op_enable;
   logic [AW-2:0] disp_addr;
   logic          bus_rd_req, bus_wr_req;
   logic [AW-1:0] bus_addr;
   logic [7:0]    bus_din, bus_dout;
   logic          bus_ack, bus_wait;
   logic [AW-1:0] ram_a;
   logic [7:0]    ram_d_in, ram_d_out;
   logic          ram_d_oe, ram_oe_l, ram_we_l;
   logic [7:0]    char_byte, attr_byte;

   always #5 clk = ~clk;

   cga_vram_arbiter #(.ADDR_W(AW), .START_LIMIT(11)) dut (
      .clk(clk), .reset_n(reset_n), .clk_seq(clk_seq), .vram_read(vram_read),
      .vram_read_a0(vram_read_a0), .vram_read_char(vram_read_char),
      .vram_read_att(vram_read_att), .isa_op_enable(isa_op_enable),
      .disp_addr(disp_addr), .bus_rd_req(bus_rd_req), .bus_wr_req(bus_wr_req),
      .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
      .bus_ack(bus_ack), .bus_wait(bus_wait), .ram_a(ram_a), .ram_d_in(ram_d_in),
      .ram_d_out(ram_d_out), .ram_d_oe(ram_d_oe), .ram_oe_l(ram_oe_l),
      .ram_we_l(ram_we_l), .char_byte(char_byte), .attr_byte(attr_byte)
   );

   logic [7:0] mem    [0:16383];
   logic [7:0] refmem [0:16383];
   assign ram_d_in = ram_oe_l ? 8'h00 : mem[ram_a];

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic [4:0]    seq;
   logic          hres;
   logic [AW-2:0] disp;

   typedef struct {
      logic          wr;
      logic          rd;
      logic [AW-1:0] addr;
      logic [7:0]    din;
      logic          wait_e;
      logic          ack_e;
      logic          we_l_e;
      logic          oe_l_e;
      logic          doe_e;
      logic [AW-1:0] a_e;
      logic [7:0]    do_e;
   } vec_t;

   vec_t wtab [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: cycle %0d phase %0d got %0h expected %0h", name, cyc, seq, act, exp);
      end
   endtask

   task automatic drive();
      logic [3:0] p4;
      logic       vr;
      p4 = seq[3:0];
      vr = (p4 <= 4'd3) && (hres || !seq[4]);
      vram_read      = vr;
      vram_read_a0   = (p4 == 4'd1) || (p4 == 4'd3);
      vram_read_char = vr && (p4 == 4'd2);
      vram_read_att  = vr && (p4 == 4'd3);
      isa_op_enable  = (p4 >= 4'd5);
      clk_seq        = seq;
      disp_addr      = disp;
   endtask

   // Called at the negedge; samples SRAM write strobes before the edge, commits after it.
   task automatic tick();
      logic          we_s;
      logic [AW-1:0] a_s;
      logic [7:0]    d_s;
      we_s = ram_we_l;
      a_s  = ram_a;
      d_s  = ram_d_out;
      @(posedge clk);
      #1;
      if (!we_s) mem[a_s] = d_s;
      seq = seq + 5'd1;
      cyc++;
      drive();
   endtask

   task automatic goto_phase(input logic [4:0] p);
      bus_wr_req = 1'b0;
      bus_rd_req = 1'b0;
      while (seq != p) begin
         @(negedge clk);
         tick();
      end
   endtask

   initial begin
      int acks, wes, waits, bad;
      logic          busy, mwr, isa, e_ack, e_wait, rq_wr, rq_rd;
      logic [AW-1:0] maddr, ea;
      logic [7:0]    mdata, edo, exp_char, exp_attr, exp_dout;
      logic          eoe, ewe, edoe;
      int            acc, elig, ack;
      logic [3:0]    p4;

      wtab[0] = '{1'b1, 1'b0, 14'h1234, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0000, 8'h00};
      wtab[1] = '{1'b0, 1'b0, 14'h1234, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0000, 8'h00};
      wtab[2] = '{1'b0, 1'b0, 14'h1234, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 14'h1234, 8'hA5};
      wtab[3] = '{1'b0, 1'b0, 14'h1234, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'h1234, 8'hA5};
      wtab[4] = '{1'b0, 1'b0, 14'h1234, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 14'h1234, 8'hA5};
      wtab[5] = '{1'b0, 1'b0, 14'h1234, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0000, 8'h00};

      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      reset_n = 1'b0; seq = 5'd4; hres = 1'b1; disp = '0;
      bus_wr_req = 1'b0; bus_rd_req = 1'b0; bus_addr = '0; bus_din = 8'h00;
      drive();
      #12;
      chk("rst_char", 32'(char_byte), 32'h00);
      chk("rst_attr", 32'(attr_byte), 32'h00);
      chk("rst_dout", 32'(bus_dout), 32'h00);
      chk("rst_ack", 32'(bus_ack), 32'h0);
      chk("rst_wait", 32'(bus_wait), 32'h0);
      chk("rst_we_l", 32'(ram_we_l), 32'h1);
      chk("rst_oe_l", 32'(ram_oe_l), 32'h1);
      chk("rst_d_oe", 32'(ram_d_oe), 32'h0);
      chk("rst_ram_a", 32'(ram_a), 32'h0);
      chk("rst_d_out", 32'(ram_d_out), 32'h0);

      // Display fetch of character/attribute pair at 0x0100/0x0101
      mem[14'h0100] = 8'h41; mem[14'h0101] = 8'h1F; disp = 13'h080;
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      goto_phase(5'd3);
      @(negedge clk);
      chk("char_ph2", 32'(char_byte), 32'h41);
      tick();
      @(negedge clk);
      chk("attr_ph3", 32'(attr_byte), 32'h1F);
      mem[14'h0100] = 8'h55;
      goto_phase(5'd19);
      @(negedge clk);
      chk("char_refetch", 32'(char_byte), 32'h55);
      tick();
      @(negedge clk);
      chk("attr_refetch", 32'(attr_byte), 32'h1F);
      mem[14'h0100] = 8'h41;
      tick();

      // Best-case write at phase 4
      goto_phase(5'd4);
      for (int i = 0; i < 6; i++) begin
         bus_wr_req = wtab[i].wr; bus_rd_req = wtab[i].rd;
         bus_addr = wtab[i].addr; bus_din = wtab[i].din;
         @(negedge clk);
         chk($sformatf("wr_wait[%0d]", i), 32'(bus_wait), 32'(wtab[i].wait_e));
         chk($sformatf("wr_ack[%0d]", i), 32'(bus_ack), 32'(wtab[i].ack_e));
         chk($sformatf("wr_we_l[%0d]", i), 32'(ram_we_l), 32'(wtab[i].we_l_e));
         chk($sformatf("wr_oe_l[%0d]", i), 32'(ram_oe_l), 32'(wtab[i].oe_l_e));
         chk($sformatf("wr_d_oe[%0d]", i), 32'(ram_d_oe), 32'(wtab[i].doe_e));
         chk($sformatf("wr_ram_a[%0d]", i), 32'(ram_a), 32'(wtab[i].a_e));
         chk($sformatf("wr_d_out[%0d]", i), 32'(ram_d_out), 32'(wtab[i].do_e));
         tick();
      end
      chk("wr_mem", 32'(mem[14'h1234]), 32'hA5);

      // Worst-case read requested at phase 12
      goto_phase(5'd12);
      bus_rd_req = 1'b1; bus_addr = 14'h1234;
      @(negedge clk);
      tick();
      bus_rd_req = 1'b0;
      for (int ph = 13; ph <= 24; ph++) begin
         @(negedge clk);
         chk($sformatf("rd_wait[%0d]", ph), 32'(bus_wait), 32'(ph <= 23));
         chk($sformatf("rd_ack[%0d]", ph), 32'(bus_ack), 32'(ph == 24));
         if (ph <= 21) begin
            chk($sformatf("rd_idle_doe[%0d]", ph), 32'(ram_d_oe), 32'h0);
            chk($sformatf("rd_idle_we[%0d]", ph), 32'(ram_we_l), 32'h1);
            if (!vram_read) begin
               chk($sformatf("rd_idle_oe[%0d]", ph), 32'(ram_oe_l), 32'h1);
               chk($sformatf("rd_idle_a[%0d]", ph), 32'(ram_a), 32'h0);
            end
         end else begin
            chk($sformatf("rd_ram_a[%0d]", ph), 32'(ram_a), 32'h1234);
            chk($sformatf("rd_oe_l[%0d]", ph), 32'(ram_oe_l), 32'(ph == 22));
         end
         if (ph == 24) chk("rd_dout", 32'(bus_dout), 32'hA5);
         tick();
      end

      // Simultaneous read+write, followed by ignored requests during the operation
      mem[14'h0200] = 8'h00;
      goto_phase(5'd4);
      bus_addr = 14'h0200; bus_din = 8'h3C;
      acks = 0; wes = 0;
      for (int i = 0; i < 40; i++) begin
         bus_wr_req = (i == 0);
         bus_rd_req = (i <= 2);
         @(negedge clk);
         acks += int'(bus_ack);
         wes  += int'(!ram_we_l);
         tick();
      end
      bus_rd_req = 1'b0;
      chk("both_acks", 32'(acks), 32'd1);
      chk("both_we_pulses", 32'(wes), 32'd1);
      chk("both_mem", 32'(mem[14'h0200]), 32'h3C);
      chk("both_no_read", 32'(bus_dout), 32'hA5);

      // Reset during the STROBE of a write
      mem[14'h0400] = 8'h11;
      goto_phase(5'd4);
      bus_wr_req = 1'b1; bus_addr = 14'h0400; bus_din = 8'hEE;
      @(negedge clk);
      tick();
      bus_wr_req = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      #1;
      chk("pre_rst_we_l", 32'(ram_we_l), 32'h0);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_we_l", 32'(ram_we_l), 32'h1);
      chk("midrst_d_oe", 32'(ram_d_oe), 32'h0);
      chk("midrst_ram_a", 32'(ram_a), 32'h0);
      chk("midrst_wait", 32'(bus_wait), 32'h0);
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      acks = 0; waits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         acks  += int'(bus_ack);
         waits += int'(bus_wait);
         tick();
      end
      chk("postrst_acks", 32'(acks), 32'd0);
      chk("postrst_waits", 32'(waits), 32'd0);
      chk("postrst_mem", 32'(mem[14'h0400]), 32'h11);

      // Randomized traffic against the scheduling model
      reset_n = 1'b0;
      for (int i = 0; i < 16384; i++) begin
         mem[i] = 8'($urandom);
         refmem[i] = mem[i];
      end
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      busy = 1'b0; mwr = 1'b0; maddr = '0; mdata = 8'h00; acc = 0; elig = -1; ack = 0;
      exp_char = 8'h00; exp_attr = 8'h00; exp_dout = 8'h00;
      for (int n = 0; n < 10000; n++) begin
         hres = (n < 5000);
         if (seq[3:0] == 4'd0) disp = 13'($urandom);
         drive();
         rq_wr = 1'b0; rq_rd = 1'b0;
         case ($urandom_range(0, 9))
            0: rq_wr = 1'b1;
            1: rq_rd = 1'b1;
            2: begin rq_wr = 1'b1; rq_rd = 1'b1; end
            default: ;
         endcase
         if (!busy) begin
            bus_addr = 14'($urandom);
            bus_din  = 8'($urandom);
         end
         bus_wr_req = rq_wr; bus_rd_req = rq_rd;
         @(negedge clk);
         p4 = seq[3:0];
         if (busy && elig < 0 && cyc > acc && p4 >= 4'd5 && p4 <= 4'd11) begin
            elig = cyc;
            ack  = cyc + 3;
         end
         isa    = busy && elig >= 0 && cyc > elig;
         e_ack  = isa && cyc == ack;
         e_wait = busy && cyc > acc && !e_ack;
         ea = '0; eoe = 1'b1; ewe = 1'b1; edoe = 1'b0; edo = 8'h00;
         if (vram_read) begin
            ea = {disp, vram_read_a0}; eoe = 1'b0;
         end else if (isa) begin
            ea = maddr; edoe = mwr; edo = mwr ? mdata : 8'h00;
            ewe = !(mwr && cyc == ack - 1);
            eoe = !(!mwr && cyc >= ack - 1);
         end
         chk("rnd_collision", 32'(vram_read && isa), 32'h0);
         chk("rnd_wait", 32'(bus_wait), 32'(e_wait));
         chk("rnd_ack", 32'(bus_ack), 32'(e_ack));
         chk("rnd_ram_a", 32'(ram_a), 32'(ea));
         chk("rnd_oe_l", 32'(ram_oe_l), 32'(eoe));
         chk("rnd_we_l", 32'(ram_we_l), 32'(ewe));
         chk("rnd_d_oe", 32'(ram_d_oe), 32'(edoe));
         chk("rnd_d_out", 32'(ram_d_out), 32'(edo));
         chk("rnd_char", 32'(char_byte), 32'(exp_char));
         chk("rnd_attr", 32'(attr_byte), 32'(exp_attr));
         chk("rnd_dout", 32'(bus_dout), 32'(exp_dout));
         if (vram_read_char) exp_char = refmem[{disp, vram_read_a0}];
         if (vram_read_att)  exp_attr = refmem[{disp, vram_read_a0}];
         if (isa && cyc == ack - 1) begin
            if (mwr) refmem[maddr] = mdata;
            else     exp_dout = refmem[maddr];
         end
         if (e_ack) begin
            busy = 1'b0;
         end else if (!busy && (rq_wr || rq_rd)) begin
            busy = 1'b1; mwr = rq_wr; maddr = bus_addr; mdata = bus_din;
            acc = cyc; elig = -1;
         end
         tick();
      end
      bus_wr_req = 1'b0; bus_rd_req = 1'b0;
      bad = 0;
      for (int i = 0; i < 16384; i++) if (mem[i] !== refmem[i]) bad++;
      chk("rnd_mem_mismatches", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
